arf_rat: RTL and testbench

- Architectural register file plus register alias table.
- Sits at the retire end of the reorder buffer: it accepts the in-order retire stream (valid, ROB id, ARF id, data) and commits results to architectural state.
- At dispatch it records which ROB entry will produce each architectural register.
- For each source operand it reports either committed ARF data or the ROB id to look up in the ROB for ready/data.

---
 rtl/arf_rat_if.sv | 47 ++++
 rtl/arf_rat.sv | 91 +++++++++
 tb/tb_arf_rat.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/arf_rat_if.sv
// Purpose : bundle of dispatch, retire, flush and source-lookup signals for arf_rat.
// Latency : n/a (wires only); lookups answer combinationally in the same cycle.
// Backpr. : none; dispatch/retire are already qualified strobes, so there is no ready.
// Ports   : master = pipeline side (drives strobes and src ids), slave = arf_rat.
interface arf_rat_if #(
   parameter int ARF_ID_WIDTH   = 5,
   parameter int ROB_ID_WIDTH   = 3,
   parameter int REG_DATA_WIDTH = 32
);
   logic                      dispatch_fire;
   logic                      dispatch_dst_valid;
   logic [ARF_ID_WIDTH-1:0]   dispatch_dst_arf_id;
   logic [ROB_ID_WIDTH-1:0]   dispatch_rob_id;

   logic [ARF_ID_WIDTH-1:0]   src1_arf_id;
   logic                      src1_renamed;
   logic [ROB_ID_WIDTH-1:0]   src1_rob_id;
   logic [REG_DATA_WIDTH-1:0] src1_reg_data;

   logic [ARF_ID_WIDTH-1:0]   src2_arf_id;
   logic                      src2_renamed;
   logic [ROB_ID_WIDTH-1:0]   src2_rob_id;
   logic [REG_DATA_WIDTH-1:0] src2_reg_data;

   logic                      retire;
   logic [ROB_ID_WIDTH-1:0]   retire_rob_id;
   logic [ARF_ID_WIDTH-1:0]   retire_arf_id;
   logic [REG_DATA_WIDTH-1:0] retire_reg_data;

   logic                      flush;

   modport master (
      output dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
      output src1_arf_id, src2_arf_id,
      output retire, retire_rob_id, retire_arf_id, retire_reg_data, flush,
      input  src1_renamed, src1_rob_id, src1_reg_data,
      input  src2_renamed, src2_rob_id, src2_reg_data
   );

   modport slave (
      input  dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
      input  src1_arf_id, src2_arf_id,
      input  retire, retire_rob_id, retire_arf_id, retire_reg_data, flush,
      output src1_renamed, src1_rob_id, src1_reg_data,
      output src2_renamed, src2_rob_id, src2_reg_data
   );
endinterface

// File: rtl/arf_rat.sv
// Purpose : architectural register file + register alias table at the ROB retire end.
// Latency : lookups combinational (retire bypass same cycle); dispatch mapping visible next cycle.
// Backpr. : none; every dispatch/retire strobe is accepted unconditionally.
// Ports   : clk, rst_aL (async active-low), io (arf_rat_if.slave: dispatch, retire, flush, 2 src ports).
module arf_rat #(
   parameter int N_ARF          = 32,
   parameter int ARF_ID_WIDTH   = 5,
   parameter int ROB_ID_WIDTH   = 3,
   parameter int REG_DATA_WIDTH = 32
) (
   input logic      clk,
   input logic      rst_aL,
   arf_rat_if.slave io
);
   logic [REG_DATA_WIDTH-1:0] data_q [N_ARF];
   logic [ROB_ID_WIDTH-1:0]   tag_q  [N_ARF];
   logic [N_ARF-1:0]          tag_valid_q;

   logic [ARF_ID_WIDTH-1:0]   src_id  [2];
   logic                      src_ren [2];
   logic [ROB_ID_WIDTH-1:0]   src_rob [2];
   logic [REG_DATA_WIDTH-1:0] src_dat [2];

   assign src_id[0] = io.src1_arf_id;
   assign src_id[1] = io.src2_arf_id;

   // Lookup sees pre-edge state only; the one exception is the retire bypass,
   // which forwards a committing value whose tag still owns the register.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         src_ren[p] = 1'b0;
         src_rob[p] = '0;
         src_dat[p] = '0;
         if (src_id[p] != '0) begin
            if (io.retire && (io.retire_arf_id == src_id[p]) &&
                tag_valid_q[src_id[p]] && (tag_q[src_id[p]] == io.retire_rob_id)) begin
               src_dat[p] = io.retire_reg_data;
            end else if (tag_valid_q[src_id[p]]) begin
               src_ren[p] = 1'b1;
               src_rob[p] = tag_q[src_id[p]];
               src_dat[p] = data_q[src_id[p]];
            end else begin
               src_dat[p] = data_q[src_id[p]];
            end
         end
      end
   end

   assign io.src1_renamed  = src_ren[0];
   assign io.src1_rob_id   = src_rob[0];
   assign io.src1_reg_data = src_dat[0];
   assign io.src2_renamed  = src_ren[1];
   assign io.src2_rob_id   = src_rob[1];
   assign io.src2_reg_data = src_dat[1];

   logic ret_wr;
   logic disp_wr;

   assign ret_wr  = io.retire && (io.retire_arf_id != '0);
   assign disp_wr = io.dispatch_fire && io.dispatch_dst_valid && (io.dispatch_dst_arf_id != '0);

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         for (int i = 0; i < N_ARF; i++) begin
            data_q[i] <= '0;
            tag_q[i]  <= '0;
         end
         tag_valid_q <= '0;
      end else begin
         for (int i = 0; i < N_ARF; i++) begin
            // Retire always commits data: retirement is in order, so even a
            // re-renamed register must hold this value architecturally.
            if (ret_wr && (io.retire_arf_id == ARF_ID_WIDTH'(i))) begin
               data_q[i] <= io.retire_reg_data;
            end
            // Priority: flush kills everything (incl. same-cycle dispatch),
            // then a new dispatch mapping beats a retire that would clear it.
            if (io.flush) begin
               tag_valid_q[i] <= 1'b0;
            end else if (disp_wr && (io.dispatch_dst_arf_id == ARF_ID_WIDTH'(i))) begin
               tag_valid_q[i] <= 1'b1;
               tag_q[i]       <= io.dispatch_rob_id;
            end else if (ret_wr && (io.retire_arf_id == ARF_ID_WIDTH'(i)) &&
                         (tag_q[i] == io.retire_rob_id)) begin
               // Only the mapping owned by this ROB entry is released.
               tag_valid_q[i] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_arf_rat.sv
module tb_arf_rat;
   logic clk;
   logic rst_aL;

   arf_rat_if bus ();

   arf_rat dut (
      .clk    (clk),
      .rst_aL (rst_aL),
      .io     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        df;
      logic [4:0]  dd;
      logic [2:0]  drob;
      logic        rt;
      logic [4:0]  rarf;
      logic [2:0]  rrob;
      logic [31:0] rdat;
      logic        fl;
      logic [4:0]  s1;
      logic        e1r;
      logic [2:0]  e1rob;
      logic [31:0] e1d;
      logic [4:0]  s2;
      logic        e2r;
      logic [2:0]  e2rob;
      logic [31:0] e2d;
   } vec_t;

   typedef struct {
      logic [4:0]  s1;
      logic        e1r;
      logic [2:0]  e1rob;
      logic [31:0] e1d;
      logic [4:0]  s2;
      logic        e2r;
      logic [2:0]  e2rob;
      logic [31:0] e2d;
   } exp_t;

   vec_t tbl[$];
   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic vec_t mkv(
      input logic df, input logic [4:0] dd, input logic [2:0] drob,
      input logic rt, input logic [4:0] rarf, input logic [2:0] rrob, input logic [31:0] rdat,
      input logic fl,
      input logic [4:0] s1, input logic e1r, input logic [2:0] e1rob, input logic [31:0] e1d,
      input logic [4:0] s2, input logic e2r, input logic [2:0] e2rob, input logic [31:0] e2d);
      vec_t v;
      v.df = df; v.dd = dd; v.drob = drob;
      v.rt = rt; v.rarf = rarf; v.rrob = rrob; v.rdat = rdat;
      v.fl = fl;
      v.s1 = s1; v.e1r = e1r; v.e1rob = e1rob; v.e1d = e1d;
      v.s2 = s2; v.e2r = e2r; v.e2rob = e2rob; v.e2d = e2d;
      return v;
   endfunction

   task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (step %0d): got 0x%08h, want 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.dispatch_fire       = 1'b0;
      bus.dispatch_dst_valid  = 1'b0;
      bus.dispatch_dst_arf_id = '0;
      bus.dispatch_rob_id     = '0;
      bus.retire              = 1'b0;
      bus.retire_rob_id       = '0;
      bus.retire_arf_id       = '0;
      bus.retire_reg_data     = '0;
      bus.flush               = 1'b0;
   endtask

   // Drive one vector's stimulus and queue what the ports must show this cycle.
   task automatic drive(input vec_t v);
      exp_t e;
      bus.dispatch_fire       = v.df;
      bus.dispatch_dst_valid  = v.df;
      bus.dispatch_dst_arf_id = v.dd;
      bus.dispatch_rob_id     = v.drob;
      bus.retire              = v.rt;
      bus.retire_rob_id       = v.rrob;
      bus.retire_arf_id       = v.rarf;
      bus.retire_reg_data     = v.rdat;
      bus.flush               = v.fl;
      bus.src1_arf_id         = v.s1;
      bus.src2_arf_id         = v.s2;
      e.s1 = v.s1; e.e1r = v.e1r; e.e1rob = v.e1rob; e.e1d = v.e1d;
      e.s2 = v.s2; e.e2r = v.e2r; e.e2rob = v.e2rob; e.e2d = v.e2d;
      sb_q.push_back(e);
   endtask

   // rob_id is only meaningful when renamed (or x0); data only when not renamed.
   task automatic check_out(input int idx);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL scoreboard (step %0d): got empty queue, want an entry", idx);
      end else begin
         e = sb_q.pop_front();
         cmp("src1_renamed", idx, 32'(bus.src1_renamed), 32'(e.e1r));
         if (e.e1r || e.s1 == 5'd0) cmp("src1_rob_id", idx, 32'(bus.src1_rob_id), 32'(e.e1rob));
         if (!e.e1r) cmp("src1_reg_data", idx, bus.src1_reg_data, e.e1d);
         cmp("src2_renamed", idx, 32'(bus.src2_renamed), 32'(e.e2r));
         if (e.e2r || e.s2 == 5'd0) cmp("src2_rob_id", idx, 32'(bus.src2_rob_id), 32'(e.e2rob));
         if (!e.e2r) cmp("src2_reg_data", idx, bus.src2_reg_data, e.e2d);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      check_out(idx);
   endtask

   initial begin
      //            df dd drob rt rarf rrob rdat          fl s1 r rob d              s2 r rob d
      tbl.push_back(mkv(0, 0, 0, 1, 5, 2, 32'hDEADBEEF, 0, 5, 0, 0, 32'h0,        0, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 32'h0));
      tbl.push_back(mkv(1, 7, 3, 0, 0, 0, 32'h0,        0, 7, 0, 0, 32'h0,        5, 0, 0, 32'hDEADBEEF));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        0, 7, 1, 3, 32'h0,        5, 0, 0, 32'hDEADBEEF));
      tbl.push_back(mkv(0, 0, 0, 1, 7, 3, 32'h1234,     0, 7, 0, 0, 32'h1234,     0, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        0, 7, 0, 0, 32'h1234,     0, 0, 0, 32'h0));
      tbl.push_back(mkv(1, 9, 1, 0, 0, 0, 32'h0,        0, 9, 0, 0, 32'h0,        7, 0, 0, 32'h1234));
      tbl.push_back(mkv(1, 9, 4, 0, 0, 0, 32'h0,        0, 9, 1, 1, 32'h0,        0, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 1, 9, 1, 32'hAA,       0, 9, 1, 4, 32'h0,        0, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        0, 9, 1, 4, 32'h0,        0, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 1, 9, 4, 32'hBB,       0, 9, 0, 0, 32'hBB,       0, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        0, 9, 0, 0, 32'hBB,       0, 0, 0, 32'h0));
      tbl.push_back(mkv(1, 6, 2, 0, 0, 0, 32'h0,        0, 6, 0, 0, 32'h0,        0, 0, 0, 32'h0));
      tbl.push_back(mkv(1, 6, 5, 1, 6, 2, 32'h55,       0, 6, 0, 0, 32'h55,       9, 0, 0, 32'hBB));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        0, 6, 1, 5, 32'h0,        0, 0, 0, 32'h0));
      tbl.push_back(mkv(1, 3, 0, 0, 0, 0, 32'h0,        0, 3, 0, 0, 32'h0,        0, 0, 0, 32'h0));
      tbl.push_back(mkv(1, 4, 1, 0, 0, 0, 32'h0,        0, 3, 1, 0, 32'h0,        4, 0, 0, 32'h0));
      tbl.push_back(mkv(1, 8, 2, 1, 3, 0, 32'h77,       1, 3, 0, 0, 32'h77,       4, 1, 1, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        0, 3, 0, 0, 32'h77,       4, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        0, 8, 0, 0, 32'h0,        6, 0, 0, 32'h55));
      tbl.push_back(mkv(1, 0, 3, 1, 0, 3, 32'hFF,       0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0));
      // Multi-cycle lead-in for the mid-run reset: reg 10 renamed, reg 11 committed.
      tbl.push_back(mkv(1, 10, 6, 1, 11, 7, 32'h99,     0, 10, 0, 0, 32'h0,       11, 0, 0, 32'h0));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 32'h0,        0, 10, 1, 6, 32'h0,       11, 0, 0, 32'h99));

      // Reset state, checked before any clock edge.
      rst_aL = 1'b0;
      idle_inputs();
      bus.src1_arf_id = 5'd5;
      bus.src2_arf_id = 5'd0;
      #2;
      begin
         exp_t e;
         e.s1 = 5'd5; e.e1r = 1'b0; e.e1rob = '0; e.e1d = '0;
         e.s2 = 5'd0; e.e2r = 1'b0; e.e2rob = '0; e.e2d = '0;
         sb_q.push_back(e);
         check_out(-1);
      end
      @(posedge clk);
      #1 rst_aL = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], i);
      end

      // Asynchronous reset between clock edges: outputs must clear without an edge.
      @(posedge clk);
      #1;
      idle_inputs();
      bus.src1_arf_id = 5'd10;
      bus.src2_arf_id = 5'd11;
      rst_aL = 1'b0;
      #1;
      begin
         exp_t e;
         e.s1 = 5'd10; e.e1r = 1'b0; e.e1rob = '0; e.e1d = '0;
         e.s2 = 5'd11; e.e2r = 1'b0; e.e2rob = '0; e.e2d = '0;
         sb_q.push_back(e);
         check_out(100);
      end
      #1 rst_aL = 1'b1;
      // State stays cleared after release: no mapping for 10, data of 11 lost.
      apply(mkv(0, 0, 0, 0, 0, 0, 32'h0, 0, 10, 0, 0, 32'h0, 11, 0, 0, 32'h0), 101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
